// File: rtl/sb_arbiter_pkg.sv
// Shared types and default widths for the single-outstanding fetch/data memory arbiter.
package sb_pkg;

    localparam int unsigned SB_ADDR_W      = 32;
    localparam int unsigned SB_DATA_W      = 32;
    localparam int unsigned SB_RSP_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

endpackage

// File: rtl/sb_arbiter_if.sv
// Fetch, data and shared memory-port signals; master is the arbiter side, slave the environment.
interface sb_arbiter_if
    import sb_pkg::*;
#(
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_un_sign;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_be;
    logic                  m_un_sign;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be, d_un_sign,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be, m_un_sign,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be, d_un_sign,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be, m_un_sign,
        output m_gnt, m_rvalid, m_rdata
    );

endinterface

// File: rtl/sb_arbiter_pick.sv
// Combinational winner selection between fetch and data; prefer breaks ties.
module sb_arb_pick
    import sb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_e prefer,
    output logic   valid,
    output owner_e owner
);

    always_comb begin
        valid = if_req | d_req;
        owner = prefer;
        if (d_req && !if_req) begin
            owner = OWN_D;
        end else if (if_req && !d_req) begin
            owner = OWN_IF;
        end
    end

endmodule

// File: rtl/sb_arbiter.sv
// Fetch/data arbiter onto one memory port, one transaction outstanding, with response timeout.
// Define SB_ARB_RR_EN for round-robin tie-breaking; default is fixed data-first priority.
module sb_arbiter
    import sb_pkg::*;
#(
    parameter int unsigned ADDR_W      = SB_ADDR_W,
    parameter int unsigned DATA_W      = SB_DATA_W,
    parameter int unsigned RSP_TIMEOUT = SB_RSP_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    sb_arbiter_if.master bus,
    output logic         err_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

    state_e              state_q, state_d;
    owner_e              own_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                un_sign_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_valid;
    owner_e              pick_owner;
    owner_e              prefer;
    logic                latch;
    logic                timeout;

    sb_arb_pick u_pick (
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .prefer (prefer),
        .valid  (pick_valid),
        .owner  (pick_owner)
    );

`ifdef SB_ARB_RR_EN
    owner_e ptr_q;

    // Point at whichever requester was not just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= OWN_D;
        end else if (state_q == REQ && bus.m_gnt) begin
            ptr_q <= (own_q == OWN_D) ? OWN_IF : OWN_D;
        end
    end

    assign prefer = ptr_q;
`else
    assign prefer = OWN_D;
`endif

    assign timeout = (RSP_TIMEOUT != 0) && (state_q == WAIT) && !bus.m_rvalid &&
                     (cnt_q == CNT_W'(RSP_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    latch   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.m_gnt) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (bus.m_rvalid || timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            own_q     <= OWN_IF;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            un_sign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                own_q <= pick_owner;
                if (pick_owner == OWN_D) begin
                    addr_q    <= bus.d_addr;
                    we_q      <= bus.d_we;
                    wdata_q   <= bus.d_wdata;
                    be_q      <= bus.d_be;
                    un_sign_q <= bus.d_un_sign;
                end else begin
                    addr_q    <= bus.if_addr;
                    we_q      <= 1'b0;
                    wdata_q   <= '0;
                    be_q      <= '1;
                    un_sign_q <= 1'b0;
                end
            end
        end
    end

    // Outputs are gated by rst so a reset cycle in REQ/WAIT shows nothing.
    always_comb begin
        bus.m_req     = 1'b0;
        bus.m_we      = 1'b0;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.m_be      = '0;
        bus.m_un_sign = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        err_o         = 1'b0;
        if (!rst) begin
            if (state_q == REQ) begin
                bus.m_req     = 1'b1;
                bus.m_we      = we_q;
                bus.m_addr    = addr_q;
                bus.m_wdata   = wdata_q;
                bus.m_be      = be_q;
                bus.m_un_sign = un_sign_q;
                if (bus.m_gnt) begin
                    if (own_q == OWN_D) bus.d_gnt = 1'b1;
                    else                bus.if_gnt = 1'b1;
                end
            end
            if (state_q == WAIT && (bus.m_rvalid || timeout)) begin
                err_o = timeout;
                if (own_q == OWN_D) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = bus.m_rvalid ? bus.m_rdata : '0;
                end else begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.m_rvalid ? bus.m_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Scoreboard bench for sb_arbiter: directed stimulus queues expected grant/response events.
module tb_sb_arbiter;
    import sb_pkg::*;

    localparam logic [4:0] F_IFG = 5'b10000;
    localparam logic [4:0] F_DG  = 5'b01000;
    localparam logic [4:0] F_IFR = 5'b00100;
    localparam logic [4:0] F_DR  = 5'b00010;
    localparam logic [4:0] F_ERR = 5'b00001;

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        un_sign;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_o;
    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sb_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .RSP_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .err_o (err_o)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic evt_t mk(input logic [4:0] f, input logic [31:0] a, input logic w,
                                input logic [3:0] b, input logic [31:0] wd, input logic u,
                                input logic [31:0] ir, input logic [31:0] dr);
        evt_t e;
        e.flags = f; e.addr = a; e.we = w; e.be = b; e.wdata = wd; e.un_sign = u;
        e.if_rdata = ir; e.d_rdata = dr;
        return e;
    endfunction

    function automatic logic [159:0] all_outs();
        return 160'({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                     bus.d_rdata, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be,
                     bus.m_un_sign, err_o});
    endfunction

    // Monitor: every cycle with a gnt/rvalid/err must match the head of the queue.
    always @(negedge clk) begin
        evt_t act;
        act = mk({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, err_o}, bus.m_addr,
                 bus.m_we, bus.m_be, bus.m_wdata, bus.m_un_sign, bus.if_rdata, bus.d_rdata);
        if (act.flags != 5'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 160'(act), 160'(0));
            end else begin
                check("event", 160'(act), 160'(exp_q.pop_front()));
            end
        end else begin
            check("quiet_rdata", 160'({bus.if_rdata, bus.d_rdata}), 160'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cmd(input string name, input logic req, input logic [31:0] addr,
                           input logic we, input logic [3:0] be, input logic [31:0] wdata,
                           input logic un);
        @(negedge clk);
        check(name, 160'({bus.m_req, bus.m_addr, bus.m_we, bus.m_be, bus.m_wdata,
                          bus.m_un_sign}),
              160'({req, addr, we, be, wdata, un}));
    endtask

    // Entered with the FSM in REQ for the given owner; leaves it back in IDLE.
    task automatic do_txn(input logic is_d, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata, input logic un,
                          input int gnt_wait, input int rsp_wait, input logic [31:0] rdata);
        for (int i = 0; i < gnt_wait; i++) begin
            chk_cmd("stall_cmd", 1'b1, addr, we, be, wdata, un);
            tick();
        end
        bus.m_gnt = 1'b1;
        exp_q.push_back(mk(is_d ? F_DG : F_IFG, addr, we, be, wdata, un, 32'h0, 32'h0));
        chk_cmd("grant_cmd", 1'b1, addr, we, be, wdata, un);
        tick();
        bus.m_gnt = 1'b0;
        if (is_d) bus.d_req = 1'b0;
        else      bus.if_req = 1'b0;
        for (int i = 0; i < rsp_wait; i++) begin
            chk_cmd("wait_cmd", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
            tick();
        end
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = rdata;
        exp_q.push_back(mk(is_d ? F_DR : F_IFR, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0,
                           is_d ? 32'h0 : rdata, is_d ? rdata : 32'h0));
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'h0;
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.d_be = 4'h0; bus.d_un_sign = 1'b0;
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;

        // Reset with busy-looking inputs: every output must stay 0.
        tick();
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1;
        bus.m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("reset_outputs", all_outs(), 160'(0));
        tick();
        rst = 1'b0;
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0;
        bus.m_rdata = 32'h0;
        tick();

        // Single fetch: m_req one cycle after if_req, response two cycles after grant.
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        chk_cmd("req_latency", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        do_txn(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1, 32'hDEAD_BEEF);

        // Tie: data store first, then the held fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h55AA;
        bus.d_be = 4'b0011; bus.d_un_sign = 1'b0;
        tick();
        do_txn(1'b1, 32'h2000, 1'b1, 4'b0011, 32'h55AA, 1'b0, 0, 0, 32'h1234_5678);
        tick();
        do_txn(1'b0, 32'h200, 1'b0, 4'hF, 32'h0, 1'b0, 1, 0, 32'hCAFE_F00D);

        // Data-only unsigned load.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44; bus.d_wdata = 32'h0;
        bus.d_be = 4'hF; bus.d_un_sign = 1'b1;
        tick();
        do_txn(1'b1, 32'h44, 1'b0, 4'hF, 32'h0, 1'b1, 0, 2, 32'h8000_0001);

        // Second tie right after a data grant, first winner stalled 5 cycles.
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h99;
        bus.d_be = 4'hC; bus.d_un_sign = 1'b0;
        tick();
`ifdef SB_ARB_RR_EN
        do_txn(1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 1'b0, 5, 0, 32'h3333_0000);
        tick();
        do_txn(1'b1, 32'h2004, 1'b1, 4'hC, 32'h99, 1'b0, 0, 0, 32'h4444_0000);
`else
        do_txn(1'b1, 32'h2004, 1'b1, 4'hC, 32'h99, 1'b0, 5, 0, 32'h4444_0000);
        tick();
        do_txn(1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 1'b0, 0, 0, 32'h3333_0000);
`endif

        // Stray m_gnt / m_rvalid in IDLE are ignored.
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5A5A_5A5A;
        chk_cmd("idle_ignore", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;

        // Timeout: fourth WAIT cycle without m_rvalid gives d_rvalid + err_o, rdata 0.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000; bus.d_wdata = 32'h0;
        bus.d_be = 4'hF; bus.d_un_sign = 1'b0;
        tick();
        bus.m_gnt = 1'b1;
        exp_q.push_back(mk(F_DG, 32'h3000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 32'h0));
        chk_cmd("timeout_grant", 1'b1, 32'h3000, 1'b0, 4'hF, 32'h0, 1'b0);
        tick();
        bus.m_gnt = 1'b0; bus.d_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_cmd("timeout_wait", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
            tick();
        end
        exp_q.push_back(mk(F_DR | F_ERR, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0));
        tick();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_0BAD;
        chk_cmd("late_rvalid_idle", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;

        // Counter restarts: response on the last allowed WAIT cycle is a normal one.
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        tick();
        do_txn(1'b0, 32'h400, 1'b0, 4'hF, 32'h0, 1'b0, 0, 3, 32'h0BAD_CAFE);

        // Reset in WAIT abandons the fetch; responses during and after reset are dropped.
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        tick();
        bus.m_gnt = 1'b1;
        exp_q.push_back(mk(F_IFG, 32'h500, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 32'h0));
        chk_cmd("reset_txn_grant", 1'b1, 32'h500, 1'b0, 4'hF, 32'h0, 1'b0);
        tick();
        bus.m_gnt = 1'b0; bus.if_req = 1'b0;
        rst = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77;
        @(negedge clk);
        check("reset_in_wait_outputs", all_outs(), 160'(0));
        tick();
        rst = 1'b0;
        chk_cmd("after_reset_idle", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
        tick();
        tick();

        check("queue_drained", 160'(exp_q.size()), 160'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
